// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and constants: FSM state encoding, frame size,
// scan-code prefixes for the downstream keyboard decoder, and a parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [7:0] BREAK_PREFIX   = 8'hF0;
    localparam logic [7:0] EXT_PREFIX     = 8'hE0;

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Parameterised first-word-fall-through FIFO; the head entry is always on rdata_o.
// A pop on a full FIFO frees a slot for a same-cycle push.
module ps2_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, frame FSM with timeout, scan-code FIFO.
// Define PS2_ERRCNT_EN to add the saturating err_count output.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter  int FIFO_DEPTH     = 8,
    parameter  int SYNC_STAGES    = 2,
    parameter  int TIMEOUT_CYCLES = 50000,
    localparam int CW             = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] fifo_count,
    output logic          frame_err,
    output logic          overflow,
`ifdef PS2_ERRCNT_EN
    output logic [7:0]    err_count,
`endif
    input  logic          clr_overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q, clk_s, data_s, fall;
    ps2_state_e             state_q, state_d;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shift_q, push_byte_q;
    logic                   parity_q, push_q, push_d, frame_err_q, err_d, overflow_q;
    logic [TW-1:0]          tcnt_q;
    logic                   timeout, fifo_full, drop;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign data_s  = data_sync_q[SYNC_STAGES-1];
    assign fall    = clk_prev_q && !clk_s;
    assign timeout = (state_q != IDLE) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            tcnt_q      <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_s;
            if (state_q == IDLE || fall) tcnt_q <= '0;
            else if (!timeout)           tcnt_q <= tcnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE:    if (!data_s) state_d = DATA;
                DATA:    if (bit_idx_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
    end

    // The stop edge decides the frame; a timeout always wins over a coincident edge.
    always_comb begin
        push_d = 1'b0;
        err_d  = timeout;
        if (fall && !timeout && state_q == STOP) begin
            if (data_s && odd_parity_ok(shift_q, parity_q)) push_d = 1'b1;
            else                                            err_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= push_d;
            frame_err_q <= err_d;
            if (push_d) push_byte_q <= shift_q;
            if (fall && !timeout) begin
                case (state_q)
                    IDLE:    bit_idx_q <= '0;
                    DATA: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                    PARITY:  parity_q <= data_s;
                    default: ;
                endcase
            end
        end
    end

    ps2_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_q),
        .wdata_i (push_byte_q),
        .pop_i   (rd_en),
        .rdata_o (rd_data),
        .full_o  (fifo_full),
        .empty_o (),
        .count_o (fifo_count)
    );

    assign rd_valid = (fifo_count != '0);
    assign drop     = push_q && fifo_full && !rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             overflow_q <= 1'b0;
        else if (drop)         overflow_q <= 1'b1;
        else if (clr_overflow) overflow_q <= 1'b0;
    end

    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

`ifdef PS2_ERRCNT_EN
    logic [7:0] errcnt_q;
    logic [8:0] errsum;

    assign errsum = (clr_overflow ? 9'd0 : {1'b0, errcnt_q}) + 9'(frame_err_q) + 9'(drop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) errcnt_q <= '0;
        else       errcnt_q <= errsum[8] ? 8'hFF : errsum[7:0];
    end

    assign err_count = errcnt_q;
`endif

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the CPU/memory block's keyboard memory-mapped register.
- Oversamples the raw ps2_clk/ps2_data pins on the system clock and deframes 11-bit device-to-host frames.
- Validates start, parity and stop bits.
- Queues good scan-code bytes in a small first-word-fall-through FIFO that the CPU pops with a one-cycle read strobe.

Parameters:
FIFO_DEPTH, 8, scan-code FIFO entries; power of two, 2..32
SYNC_STAGES, 2, flip-flops in each pin synchroniser; minimum 2
TIMEOUT_CYCLES, 50000, system clocks with no ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz)

Ports:
clk  in  1  system clock; all logic is on its rising edge
reset  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
rd_en  in  1  pop strobe from CPU; one pop per high cycle
rd_data  out  8  FIFO head byte; valid only when rd_valid=1
rd_valid  out  1  FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  out  1  one-cycle pulse on a rejected or timed-out frame
overflow  out  1  sticky; a good byte was dropped because the FIFO was full
clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync release) values:
  - FSM = IDLE; FIFO empty.
  - rd_valid=0, rd_data=0, fifo_count=0, frame_err=0, overflow=0.
  - Synchroniser flops = 1; timeout counter = 0.
- Both pins pass through SYNC_STAGES flops. A falling edge is sync ps2_clk previous=1 and current=0. ps2_data is sampled on the same cycle the edge is detected.
- FSM states, advancing only on a falling edge:
  - IDLE: data=0 -> DATA with bit index 0; data=1 -> stay in IDLE, no error (idle-line noise).
  - DATA: shift in LSB first; after bit 7 -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: go to IDLE. Frame is good iff stop=1 and XOR(data, parity)=1 (odd parity).
- Good frame: push in the cycle after the stop edge is detected. rd_valid is high one cycle after that. Latency from stop edge detection to rd_valid=1 is 2 clk.
- Bad frame: no push; frame_err pulses 1 cycle; FSM returns to IDLE.
- Timeout:
  - Counter clears on every falling edge and while in IDLE.
  - Reaching TIMEOUT_CYCLES-1 outside IDLE forces IDLE, pulses frame_err and discards the partial byte.
- FIFO (first-word-fall-through):
  - rd_data always shows the oldest entry.
  - rd_en while empty is ignored; no underflow and no state change.
  - Push and pop in the same cycle:
    - both happen; count unchanged;
    - this also holds when full, since the pop frees the slot;
    - when empty with a push, rd_en is ignored and the byte lands.
  - Push while full with no pop: byte dropped, overflow <= 1.
  - clr_overflow coinciding with a new drop: set wins.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; count saturates at FIFO_DEPTH.
- Reset mid-frame discards the frame and all FIFO contents immediately.

Optional Feature:
PS2_ERRCNT_EN
- Defined:
  - Adds output err_count [7:0], saturating at 255.
  - Increments on each frame_err pulse and each overflow drop event; a same-cycle pair counts +2, saturating.
  - Cleared by reset and by clr_overflow.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - PS2_FRAME_BITS=11;
  - scan-code constants BREAK_PREFIX=8'hF0 and EXT_PREFIX=8'hE0, used by the downstream keyboard decoder.
- One sub-module is natural: ps2_fifo, a parameterised synchronous FWFT FIFO. It exposes push/pop/full/empty/count and is reusable by other memory-mapped peripherals.
- Synchroniser and edge detect stay inline.

Test Plan:
1. Send frame for 8'h1C (bits LSB first 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz -> 2 clk after stop edge: rd_valid=1, rd_data=8'h1C, fifo_count=1; rd_en for 1 cycle -> rd_valid=0.
2. Send 8'hF0 (parity 1) then 8'h1C without popping -> fifo_count=2, rd_data=F0; one pop -> rd_data=1C.
3. Send 8'h1C with parity bit 1 -> frame_err one-cycle pulse, fifo_count stays 0. Repeat with stop=0 -> same result.
4. Send start bit plus 3 data bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE. A following good 8'h5A frame -> rd_data=8'h5A.
5. Fill FIFO with 8 bytes, send a 9th -> overflow=1, fifo_count=8, head unchanged. Then 9th byte again with rd_en asserted on its push cycle -> count stays 8, newest entry = 9th byte. clr_overflow -> overflow=0.
6. Assert reset mid-frame after bit 4 with 3 bytes queued -> all outputs at reset values. Deassert and send 8'h29 -> rd_data=8'h29, fifo_count=1.
